// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types and mode encodings for decoder_sequencer
// Contents: mode_t (command modes), state_t (sequencer FSM states),
// and the raw 2-bit mode encodings used on the in_mode port.
package decoder_pkg;

    localparam int MODE_WIDTH = 2;

    localparam logic [MODE_WIDTH-1:0] MODE_HOLD_ENC  = 2'b00;
    localparam logic [MODE_WIDTH-1:0] MODE_PULSE_ENC = 2'b01;
    localparam logic [MODE_WIDTH-1:0] MODE_SCAN_ENC  = 2'b10;
    localparam logic [MODE_WIDTH-1:0] MODE_CLEAR_ENC = 2'b11;

    typedef enum logic [MODE_WIDTH-1:0] {
        MODE_HOLD  = MODE_HOLD_ENC,
        MODE_PULSE = MODE_PULSE_ENC,
        MODE_SCAN  = MODE_SCAN_ENC,
        MODE_CLEAR = MODE_CLEAR_ENC
    } mode_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/decoder_sequencer_onehot.sv
// rtl/decoder_sequencer_onehot.sv - combinational binary-to-one-hot map with range flag
// Ports:
//   idx       in   ENCODE_WIDTH  binary index
//   onehot    out  DECODE_WIDTH  one-hot of idx, all-zero when idx is out of range
//   in_range  out  1             idx < DECODE_WIDTH
module onehot_decode #(
    parameter int ENCODE_WIDTH = 2,
    parameter int DECODE_WIDTH = 2 ** ENCODE_WIDTH
) (
    input  logic [ENCODE_WIDTH-1:0] idx,
    output logic [DECODE_WIDTH-1:0] onehot,
    output logic                    in_range
);

    always_comb begin
        onehot   = '0;
        in_range = (int'(idx) < DECODE_WIDTH);
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            onehot[i] = (int'(idx) == i);
        end
    end

endmodule

// File: rtl/decoder_sequencer.sv
// rtl/decoder_sequencer.sv - registered one-hot decoder with hold, pulse and scan modes
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   command handshake (in_ready drops while ACTIVE or on abort)
//   in_sel              binary select / scan start index
//   in_mode             00 HOLD, 01 PULSE, 10 SCAN, 11 CLEAR
//   in_dwell            each active step lasts in_dwell+1 cycles
//   abort               cancels a timed operation; blocks acceptance in IDLE
//   out                 registered one-hot output or all-zero
//   busy                timed operation in progress
//   done                one-cycle pulse on normal completion of PULSE/SCAN
//   err                 one-cycle pulse when an accepted in_sel is out of range
module decoder_sequencer
    import decoder_pkg::*;
#(
    parameter int ENCODE_WIDTH = 2,
    parameter int DECODE_WIDTH = 2 ** ENCODE_WIDTH,
    parameter int DWELL_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ENCODE_WIDTH-1:0] in_sel,
    input  logic [1:0]              in_mode,
    input  logic [DWELL_WIDTH-1:0]  in_dwell,
    input  logic                    abort,
    output logic [DECODE_WIDTH-1:0] out,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    // Step counter is one bit wider than the index so it can hold DECODE_WIDTH
    // itself when DECODE_WIDTH == 2**ENCODE_WIDTH.
    localparam logic [ENCODE_WIDTH:0]   STEPS    = (ENCODE_WIDTH + 1)'(DECODE_WIDTH);
    localparam logic [ENCODE_WIDTH-1:0] LAST_IDX = ENCODE_WIDTH'(DECODE_WIDTH - 1);

    state_t                  state, state_nxt;
    logic [ENCODE_WIDTH-1:0] idx, idx_nxt, idx_wrap, dec_idx;
    logic [DWELL_WIDTH-1:0]  dwell_cnt, dwell_cnt_nxt;
    logic [DWELL_WIDTH-1:0]  dwell_len, dwell_len_nxt;
    logic [ENCODE_WIDTH:0]   step_cnt, step_cnt_nxt;
    logic                    scan_r, scan_nxt;
    logic [DECODE_WIDTH-1:0] out_nxt, dec_onehot;
    logic                    dec_in_range;
    logic                    done_nxt, err_nxt;
    logic                    accept, step_end, run_end, timed_cmd;
    mode_t                   cmd_mode;

    assign in_ready  = (state == ST_IDLE) && !abort;
    assign accept    = in_valid && in_ready;
    assign cmd_mode  = mode_t'(in_mode);
    assign timed_cmd = (cmd_mode == MODE_PULSE) || (cmd_mode == MODE_SCAN);
    assign busy      = (state == ST_ACTIVE);

    assign step_end = (dwell_cnt == '0);
    // A pulse is a single step; a scan ends after its DECODE_WIDTH-th step.
    assign run_end  = step_end && (!scan_r || (step_cnt == STEPS));
    assign idx_wrap = (idx == LAST_IDX) ? '0 : idx + 1'b1;

    // The single decoder sees the command select while idle and the upcoming
    // scan index while active, so the next step's one-hot is registered with
    // no gap cycle between steps.
    assign dec_idx = (state == ST_ACTIVE) ? idx_wrap : in_sel;

    onehot_decode #(
        .ENCODE_WIDTH (ENCODE_WIDTH),
        .DECODE_WIDTH (DECODE_WIDTH)
    ) u_onehot_decode (
        .idx      (dec_idx),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && dec_in_range && timed_cmd) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (abort || run_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output and counter next values
    always_comb begin
        out_nxt       = out;
        idx_nxt       = idx;
        dwell_cnt_nxt = dwell_cnt;
        dwell_len_nxt = dwell_len;
        step_cnt_nxt  = step_cnt;
        scan_nxt      = scan_r;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!dec_in_range) begin
                        out_nxt = '0;
                        err_nxt = 1'b1;
                    end else begin
                        case (cmd_mode)
                            MODE_HOLD:  out_nxt = dec_onehot;
                            MODE_CLEAR: out_nxt = '0;
                            MODE_PULSE, MODE_SCAN: begin
                                out_nxt       = dec_onehot;
                                idx_nxt       = in_sel;
                                dwell_cnt_nxt = in_dwell;
                                dwell_len_nxt = in_dwell;
                                step_cnt_nxt  = (ENCODE_WIDTH + 1)'(1);
                                scan_nxt      = (cmd_mode == MODE_SCAN);
                            end
                            default: out_nxt = '0;
                        endcase
                    end
                end
            end
            ST_ACTIVE: begin
                if (abort) begin
                    out_nxt = '0;
                end else if (!step_end) begin
                    dwell_cnt_nxt = dwell_cnt - 1'b1;
                end else if (run_end) begin
                    out_nxt  = '0;
                    done_nxt = 1'b1;
                end else begin
                    idx_nxt       = idx_wrap;
                    out_nxt       = dec_onehot;
                    dwell_cnt_nxt = dwell_len;
                    step_cnt_nxt  = step_cnt + 1'b1;
                end
            end
            default: out_nxt = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            idx       <= '0;
            dwell_cnt <= '0;
            dwell_len <= '0;
            step_cnt  <= '0;
            scan_r    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            out       <= out_nxt;
            idx       <= idx_nxt;
            dwell_cnt <= dwell_cnt_nxt;
            dwell_len <= dwell_len_nxt;
            step_cnt  <= step_cnt_nxt;
            scan_r    <= scan_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

endmodule
